// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end: fetch FSM states, the NOP
// encoding and the default boot address.
package riscv_pkg;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: request, wait for the word,
// hold it for the consumer, follow redirects and trap misaligned targets.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         discard_q, discard_d;
    logic         redirect_bad;

    assign redirect_bad = redirect && is_misaligned(redirect_pc);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        discard_d  = discard_q;

        unique case (state_q)
            FETCH: begin
                if (redirect_bad) begin
                    state_d = FAULT;
                end else if (redirect) begin
                    pc_d = redirect_pc;
                end else begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect_bad) begin
                    state_d   = FAULT;
                    discard_d = 1'b0;
                end else if (imem_rvalid) begin
                    // A redirect in the same cycle kills the arriving word just
                    // like an earlier one does, so no discard flag is left behind.
                    if (redirect || discard_q) begin
                        if (redirect) begin
                            pc_d = redirect_pc;
                        end
                        discard_d = 1'b0;
                        state_d   = FETCH;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        state_d    = ISSUE;
                    end
                end else if (redirect) begin
                    pc_d      = redirect_pc;
                    discard_d = 1'b1;
                end
            end

            ISSUE: begin
                if (redirect_bad) begin
                    state_d = FAULT;
                end else if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end

            FAULT: begin
                discard_d = 1'b0;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= INSTR_NOP;
            instr_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            discard_q  <= discard_d;
        end
    end

    // The request is the only output that must react to redirect in-cycle.
    assign imem_req    = (state_q == FETCH) && !redirect && !rst;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == ISSUE);
    assign fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run checked
// against a request/response-level reference model of the fetch protocol.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    logic        rst2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_rvalid2;
    logic [31:0] imem_rdata2;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;
    logic        instr_valid2;
    logic        instr_ready2;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic        fetch_fault2;

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk        (clk),
        .rst        (rst2),
        .imem_req   (imem_req2),
        .imem_addr  (imem_addr2),
        .imem_rvalid(imem_rvalid2),
        .imem_rdata (imem_rdata2),
        .instr      (instr2),
        .instr_pc   (instr_pc2),
        .instr_valid(instr_valid2),
        .instr_ready(instr_ready2),
        .redirect   (redirect2),
        .redirect_pc(redirect_pc2),
        .fetch_fault(fetch_fault2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what the consumer and memory should see.
    logic [31:0] exp_fetch;
    logic        held;
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    logic        live;
    logic        outstanding;
    logic        fault_m;
    logic [31:0] req_addr;

    // Memory responder state.
    int          mem_cnt;
    int          mem_lat;
    logic        rand_lat;
    logic [31:0] mem_addr;

    // Values sampled in the most recent cycle.
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [31:0] s_pc;
    logic        s_fault;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_fetch   = 32'h0000_0000;
        held        = 1'b0;
        held_pc     = '0;
        held_instr  = '0;
        live        = 1'b0;
        outstanding = 1'b0;
        fault_m     = 1'b0;
        req_addr    = '0;
        mem_cnt     = -1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        chk("rst_instr", instr, INSTR_NOP);
        chk("rst_instr_pc", instr_pc, 32'h0000_0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic cycle(input logic rd, input logic [31:0] rpc, input logic rdy, input logic stray);
        logic        rv;
        logic [31:0] rdat;
        logic        exp_req;
        rv   = 1'b0;
        rdat = $urandom;
        if (mem_cnt == 0) begin
            rv      = 1'b1;
            rdat    = memfn(mem_addr);
            mem_cnt = -1;
        end else if (mem_cnt > 0) begin
            mem_cnt--;
        end
        if (stray && !rv) begin
            rv   = 1'b1;
            rdat = 32'hDEAD_BEEF;
        end
        imem_rvalid = rv;
        imem_rdata  = rdat;
        redirect    = rd;
        redirect_pc = rpc;
        instr_ready = rdy;
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        s_instr = instr;
        s_pc    = instr_pc;
        s_fault = fetch_fault;

        exp_req = !fault_m && !held && !outstanding && !rd;
        chk("imem_req", 32'(s_req), 32'(exp_req));
        if (s_req && exp_req) chk("imem_addr", s_addr, exp_fetch);
        chk("instr_valid", 32'(s_valid), 32'(held));
        if (held) begin
            chk("instr", s_instr, held_instr);
            chk("instr_pc", s_pc, held_pc);
        end
        chk("fetch_fault", 32'(s_fault), 32'(fault_m));

        if (!fault_m) begin
            if (rd) begin
                if (rpc[1:0] != 2'b00) fault_m = 1'b1;
                else exp_fetch = rpc;
                held = 1'b0;
                live = 1'b0;
            end else if (held && rdy) begin
                held      = 1'b0;
                exp_fetch = held_pc + 32'd4;
            end
        end
        if (rv && outstanding) begin
            outstanding = 1'b0;
            if (live && !fault_m) begin
                held       = 1'b1;
                held_pc    = req_addr;
                held_instr = rdat;
            end
            live = 1'b0;
        end
        if (s_req) begin
            outstanding = 1'b1;
            live        = 1'b1;
            req_addr    = s_addr;
            if (rand_lat) mem_lat = $urandom_range(1, 4);
            mem_cnt  = mem_lat - 1;
            mem_addr = s_addr;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] first_instr;
        logic [31:0] first_pc;
        int          n;
        logic        found;

        rst2         = 1'b1;
        redirect2    = 1'b0;
        redirect_pc2 = '0;
        instr_ready2 = 1'b0;
        imem_rvalid2 = 1'b0;
        imem_rdata2  = '0;
        mem_lat      = 1;
        rand_lat     = 1'b0;
        model_reset();

        // Reset release, 1-cycle memory, ready high.
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t020_req", 32'(s_req), 32'd1);
        chk("t020_addr", s_addr, 32'h0000_0000);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t020_valid", 32'(s_valid), 32'd1);
        chk("t020_instr", s_instr, 32'h0000_0093);
        chk("t020_pc", s_pc, 32'h0000_0000);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("t020_next_addr", s_addr, 32'h0000_0004);

        // Backpressure in ISSUE, with a stray rvalid that must be ignored.
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        first_instr = s_instr;
        first_pc    = s_pc;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b0, (i == 2));
            if (s_req) n++;
            if (s_instr !== first_instr || s_pc !== first_pc) n++;
        end
        chk("t021_stable_noreq", 32'(n), 32'd0);
        chk("t021_pc", first_pc, 32'h0000_0004);
        cycle(1'b0, '0, 1'b1, 1'b0);
        mem_lat = 3;
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("t021_next_addr", s_addr, 32'h0000_0008);

        // Redirect while waiting on a 3-cycle memory: stale word dropped.
        cycle(1'b1, 32'h0000_0100, 1'b1, 1'b0);
        found = 1'b0;
        n = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            if (s_valid) n++;
            found = s_req;
        end
        chk("t022_found_req", 32'(found), 32'd1);
        chk("t022_no_valid", 32'(n), 32'd0);
        chk("t022_addr", s_addr, 32'h0000_0100);

        // Redirect with ready high in ISSUE wins over pc+4.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            found = s_valid;
        end
        chk("t023_found_valid", 32'(found), 32'd1);
        cycle(1'b1, 32'h0000_0040, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t023_req", 32'(s_req), 32'd1);
        chk("t023_addr", s_addr, 32'h0000_0040);

        // Reset mid-transaction; a late rvalid in the first cycle is ignored.
        cycle(1'b0, '0, 1'b1, 1'b0);
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("t017_addr", s_addr, 32'h0000_0000);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            found = s_valid;
        end
        chk("t017_found_valid", 32'(found), 32'd1);
        chk("t017_instr", s_instr, 32'h0000_0093);

        // Misaligned redirect: sticky fault, no requests until reset.
        mem_lat = 1;
        cycle(1'b1, 32'h0000_0102, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
            if (s_req) n++;
        end
        chk("t024_fault", 32'(s_fault), 32'd1);
        chk("t024_no_req", 32'(n), 32'd0);
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t024_restart_fault", 32'(s_fault), 32'd0);
        chk("t024_restart_addr", s_addr, 32'h0000_0000);

        // Randomized traffic.
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic        rd;
            logic [31:0] rpc;
            logic        st;
            rd  = ($urandom_range(0, 9) == 0);
            rpc = $urandom & 32'h0000_03FC;
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
            if ($urandom_range(0, 59) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            st = !outstanding && ($urandom_range(0, 7) == 0);
            if (fault_m && $urandom_range(0, 3) == 0) do_reset();
            else cycle(rd, rpc, 1'($urandom_range(0, 1)), st);
        end

        // Non-zero RESET_PC wraps to zero after one handshake.
        #1;
        chk("t025_rst_pc", instr_pc2, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        #1;
        chk("t025_req", 32'(imem_req2), 32'd1);
        chk("t025_addr", imem_addr2, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        imem_rvalid2 = 1'b1;
        imem_rdata2  = 32'h0000_0093;
        @(posedge clk);
        #1;
        imem_rvalid2 = 1'b0;
        instr_ready2 = 1'b1;
        #1;
        chk("t025_valid", 32'(instr_valid2), 32'd1);
        chk("t025_instr_pc", instr_pc2, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        instr_ready2 = 1'b0;
        #1;
        chk("t025_wrap_req", 32'(imem_req2), 32'd1);
        chk("t025_wrap_addr", imem_addr2, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
